// File: rtl/systolic_mm_engine_if.sv
// rtl/systolic_mm_engine_if.sv - job/beat/result bundle between a driver and systolic_mm_engine
//
// Purpose: groups the job handshake, the operand beat stream and the result
// signals of the systolic matrix-multiply engine.
// Signals:
//   start      driver -> engine  job request (sampled in IDLE)
//   in_valid   driver -> engine  x_col/w_row beat valid
//   in_ready   engine -> driver  beat accepted when in_valid && in_ready
//   x_col      driver -> engine  X column, element i at [DATA_WIDTH*i +: DATA_WIDTH]
//   w_row      driver -> engine  W row, element j at [DATA_WIDTH*j +: DATA_WIDTH]
//   y          engine -> driver  Y[m][k] at [ACC_WIDTH*(m*K+k) +: ACC_WIDTH]
//   out_valid  engine -> driver  y holds a complete result
//   out_ready  driver -> engine  result taken when out_valid && out_ready
//   busy       engine -> driver  engine not in IDLE
//   ovf        engine -> driver  sticky accumulator overflow flag
interface systolic_mm_engine_if #(
  parameter int M          = 4,
  parameter int K          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
);
  logic                          start;
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_WIDTH*M-1:0]       x_col;
  logic [DATA_WIDTH*K-1:0]       w_row;
  logic [ACC_WIDTH*M*K-1:0]      y;
  logic                          out_valid;
  logic                          out_ready;
  logic                          busy;
  logic                          ovf;

  modport master (
    output start, in_valid, x_col, w_row, out_ready,
    input  in_ready, y, out_valid, busy, ovf
  );

  modport slave (
    input  start, in_valid, x_col, w_row, out_ready,
    output in_ready, y, out_valid, busy, ovf
  );
endinterface

// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - output-stationary M x K systolic array computing Y = X * W
//
// Purpose: accepts N beats (one X column and one W row each), streams them
// through skewed input registers into an M x K grid of signed MACs, drains the
// array for M+K-1 cycles and presents Y until the consumer takes it.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   sa_if  systolic_mm_engine_if.slave (start, beat stream, result, busy, ovf)
// Optional feature: define SA_SATURATE_EN to make accumulators saturate and
// drive the sticky ovf flag; otherwise accumulators wrap and ovf is 0.
module systolic_mm_engine #(
  parameter int M          = 4,
  parameter int N          = 8,
  parameter int K          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  systolic_mm_engine_if.slave   sa_if
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int CW = $clog2(N + M + K + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;

  // clr: job accepted, wipe all datapath state; adv: array takes one step.
  logic clr;
  logic adv;
  assign clr = (state_q == S_IDLE) && sa_if.start;
  assign adv = ((state_q == S_LOAD) && sa_if.in_valid) || (state_q == S_DRAIN);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (sa_if.start) begin
          state_q    <= S_LOAD;
          cnt_q      <= '0;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b1;
        end
        S_LOAD: if (sa_if.in_valid) begin
          if (cnt_q == CW'(N - 1)) begin
            state_q    <= S_DRAIN;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DRAIN: begin
          if (cnt_q == CW'(M + K - 2)) begin
            state_q     <= S_DONE;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: if (sa_if.out_ready) begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Operand sources: live beat data in LOAD, zeros while draining.
  logic signed [DW-1:0] x_src [M];
  logic signed [DW-1:0] w_src [K];
  always_comb begin
    for (int i = 0; i < M; i++) begin
      x_src[i] = (state_q == S_LOAD) ? $signed(sa_if.x_col[DW*i +: DW]) : '0;
    end
    for (int j = 0; j < K; j++) begin
      w_src[j] = (state_q == S_LOAD) ? $signed(sa_if.w_row[DW*j +: DW]) : '0;
    end
  end

  // Skew: X row i and W column j are delayed i / j advances so that
  // X[i][n] and W[n][j] meet in PE(i,j) on the same advance.
  logic signed [DW-1:0] xin [M];
  logic signed [DW-1:0] win [K];

  for (genvar gi = 0; gi < M; gi++) begin : g_xskew
    if (gi == 0) begin : g_direct
      assign xin[gi] = x_src[gi];
    end else begin : g_delay
      logic signed [DW-1:0] sk_q [gi];
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int s = 0; s < gi; s++) sk_q[s] <= '0;
        end else if (clr) begin
          for (int s = 0; s < gi; s++) sk_q[s] <= '0;
        end else if (adv) begin
          sk_q[0] <= x_src[gi];
          for (int s = 1; s < gi; s++) sk_q[s] <= sk_q[s-1];
        end
      end
      assign xin[gi] = sk_q[gi-1];
    end
  end

  for (genvar gj = 0; gj < K; gj++) begin : g_wskew
    if (gj == 0) begin : g_direct
      assign win[gj] = w_src[gj];
    end else begin : g_delay
      logic signed [DW-1:0] sk_q [gj];
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int s = 0; s < gj; s++) sk_q[s] <= '0;
        end else if (clr) begin
          for (int s = 0; s < gj; s++) sk_q[s] <= '0;
        end else if (adv) begin
          sk_q[0] <= w_src[gj];
          for (int s = 1; s < gj; s++) sk_q[s] <= sk_q[s-1];
        end
      end
      assign win[gj] = sk_q[gj-1];
    end
  end

  // PE grid: x_q moves right, w_q moves down, acc_q stays put.
  logic signed [DW-1:0]   x_q   [M][K];
  logic signed [DW-1:0]   w_q   [M][K];
  logic signed [AW-1:0]   acc_q [M][K];
  logic signed [AW-1:0]   acc_d [M][K];
  logic signed [DW-1:0]   a_in  [M][K];
  logic signed [DW-1:0]   b_in  [M][K];
  logic signed [2*DW-1:0] prod  [M][K];
  logic signed [AW-1:0]   pext  [M][K];
`ifdef SA_SATURATE_EN
  logic [M*K-1:0]         ovf_hit;
`endif

  for (genvar gi = 0; gi < M; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_col
      if (gj == 0) begin : g_xl
        assign a_in[gi][gj] = xin[gi];
      end else begin : g_xn
        assign a_in[gi][gj] = x_q[gi][gj-1];
      end
      if (gi == 0) begin : g_wt
        assign b_in[gi][gj] = win[gj];
      end else begin : g_wn
        assign b_in[gi][gj] = w_q[gi-1][gj];
      end
      assign prod[gi][gj] = a_in[gi][gj] * b_in[gi][gj];
      assign pext[gi][gj] = AW'(prod[gi][gj]);
`ifdef SA_SATURATE_EN
      // One guard bit: overflow when the two top bits of the sum disagree.
      logic signed [AW:0] sum;
      assign sum = {acc_q[gi][gj][AW-1], acc_q[gi][gj]} + {pext[gi][gj][AW-1], pext[gi][gj]};
      assign ovf_hit[gi*K+gj] = sum[AW] ^ sum[AW-1];
      assign acc_d[gi][gj] = !ovf_hit[gi*K+gj] ? sum[AW-1:0] :
                             (sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}});
`else
      assign acc_d[gi][gj] = acc_q[gi][gj] + pext[gi][gj];
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < M; i++) for (int j = 0; j < K; j++) begin
        acc_q[i][j] <= '0; x_q[i][j] <= '0; w_q[i][j] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < M; i++) for (int j = 0; j < K; j++) begin
        acc_q[i][j] <= '0; x_q[i][j] <= '0; w_q[i][j] <= '0;
      end
    end else if (adv) begin
      for (int i = 0; i < M; i++) for (int j = 0; j < K; j++) begin
        acc_q[i][j] <= acc_d[i][j];
        x_q[i][j]   <= a_in[i][j];
        w_q[i][j]   <= b_in[i][j];
      end
    end
  end

`ifdef SA_SATURATE_EN
  logic ovf_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  ovf_q <= 1'b0;
    else if (clr)               ovf_q <= 1'b0;
    else if (adv && |ovf_hit)   ovf_q <= 1'b1;
  end
  assign sa_if.ovf = ovf_q;
`else
  assign sa_if.ovf = 1'b0;
`endif

  // y is the accumulator grid itself: frozen in DONE and IDLE, cleared on LOAD entry.
  logic [AW*M*K-1:0] y_flat;
  always_comb begin
    y_flat = '0;
    for (int i = 0; i < M; i++) for (int j = 0; j < K; j++) begin
      y_flat[AW*(i*K+j) +: AW] = acc_q[i][j];
    end
  end

  assign sa_if.y         = y_flat;
  assign sa_if.in_ready  = in_ready_q;
  assign sa_if.out_valid = out_valid_q;
  assign sa_if.busy      = busy_q;
endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb/tb_systolic_mm_engine.sv - directed self-checking bench for systolic_mm_engine
module tb_systolic_mm_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // A: 2x2x2 job, B: 1x1x1 jobs, C: N=4 overflow job
  systolic_mm_engine_if #(.M(2), .K(2), .DATA_WIDTH(8), .ACC_WIDTH(16)) a_if ();
  systolic_mm_engine_if #(.M(1), .K(1), .DATA_WIDTH(8), .ACC_WIDTH(16)) b_if ();
  systolic_mm_engine_if #(.M(1), .K(1), .DATA_WIDTH(8), .ACC_WIDTH(16)) c_if ();

  systolic_mm_engine #(.M(2), .N(2), .K(2), .DATA_WIDTH(8), .ACC_WIDTH(16)) u_a (
    .clk_i(clk), .rst_i(rst), .sa_if(a_if));
  systolic_mm_engine #(.M(1), .N(1), .K(1), .DATA_WIDTH(8), .ACC_WIDTH(16)) u_b (
    .clk_i(clk), .rst_i(rst), .sa_if(b_if));
  systolic_mm_engine #(.M(1), .N(4), .K(1), .DATA_WIDTH(8), .ACC_WIDTH(16)) u_c (
    .clk_i(clk), .rst_i(rst), .sa_if(c_if));

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] a_y(input int e);
    return a_if.y[16*e +: 16];
  endfunction

  task automatic a_check_y(input string pfx);
    check_eq({pfx, "_y00"}, a_y(0), 19);
    check_eq({pfx, "_y01"}, a_y(1), 22);
    check_eq({pfx, "_y10"}, a_y(2), 43);
    check_eq({pfx, "_y11"}, a_y(3), 50);
  endtask

  // X = [[1,2],[3,4]], W = [[5,6],[7,8]]. total counts negedges from beat 0
  // setup to out_valid; tail counts negedges after the final beat edge.
  task automatic a_job(input int gap, input bit wait_done, output int total, output int tail);
    total = 0;
    tail  = 0;
    @(negedge clk) a_if.start = 1'b1;
    @(negedge clk) a_if.start = 1'b0;
    check_eq("a_in_ready_load", a_if.in_ready, 1);
    check_eq("a_busy_load", a_if.busy, 1);
    a_if.in_valid = 1'b1; a_if.x_col = {8'd3, 8'd1}; a_if.w_row = {8'd6, 8'd5};
    @(negedge clk) total++;
    a_if.in_valid = 1'b0; a_if.x_col = 16'hffff; a_if.w_row = 16'hffff;
    repeat (gap) begin @(negedge clk) total++; end
    a_if.in_valid = 1'b1; a_if.x_col = {8'd4, 8'd2}; a_if.w_row = {8'd8, 8'd7};
    @(negedge clk) total++;
    a_if.in_valid = 1'b0;
    if (wait_done) begin
      while (!a_if.out_valid && tail < 50) begin
        @(negedge clk);
        tail++;
        total++;
      end
      check_eq("a_out_valid_seen", a_if.out_valid, 1);
    end
  endtask

  task automatic a_release();
    a_if.out_ready = 1'b1;
    @(negedge clk) a_if.out_ready = 1'b0;
  endtask

  task automatic b_job(input logic [7:0] x, input logic [7:0] w, output int tail);
    tail = 0;
    @(negedge clk) b_if.start = 1'b1;
    @(negedge clk) b_if.start = 1'b0;
    b_if.in_valid = 1'b1; b_if.x_col = x; b_if.w_row = w;
    @(negedge clk) b_if.in_valid = 1'b0;
    while (!b_if.out_valid && tail < 50) begin
      @(negedge clk);
      tail++;
    end
    check_eq("b_out_valid_seen", b_if.out_valid, 1);
  endtask

  int tot0, tail0, tot2, tail2, tmp, ttmp;

  initial begin
    a_if.start = 0; a_if.in_valid = 0; a_if.x_col = '0; a_if.w_row = '0; a_if.out_ready = 0;
    b_if.start = 0; b_if.in_valid = 0; b_if.x_col = '0; b_if.w_row = '0; b_if.out_ready = 0;
    c_if.start = 0; c_if.in_valid = 0; c_if.x_col = '0; c_if.w_row = '0; c_if.out_ready = 0;

    repeat (2) @(negedge clk);
    check_eq("rst_y", a_if.y, 0);
    check_eq("rst_out_valid", a_if.out_valid, 0);
    check_eq("rst_in_ready", a_if.in_ready, 0);
    check_eq("rst_busy", a_if.busy, 0);
    check_eq("rst_ovf", a_if.ovf, 0);
    rst = 1'b0;

    // in_valid while idle must be ignored
    @(negedge clk) a_if.in_valid = 1'b1; a_if.x_col = 16'h7f7f; a_if.w_row = 16'h7f7f;
    @(negedge clk);
    check_eq("idle_busy", a_if.busy, 0);
    check_eq("idle_in_ready", a_if.in_ready, 0);
    check_eq("idle_y", a_if.y, 0);
    a_if.in_valid = 1'b0;

    // basic job
    a_job(0, 1'b1, tot0, tail0);
    check_eq("a_tail", tail0, 3);
    check_eq("a_total", tot0, 5);
    a_check_y("a0");
    check_eq("a_ovf", a_if.ovf, 0);

    // hold in DONE with start pulses
    for (int c = 0; c < 10; c++) begin
      a_if.start = c[0];
      @(negedge clk);
      check_eq("hold_out_valid", a_if.out_valid, 1);
      check_eq("hold_busy", a_if.busy, 1);
      check_eq("hold_y00", a_y(0), 19);
      check_eq("hold_y11", a_y(3), 50);
    end
    a_if.start = 1'b1; a_if.out_ready = 1'b1;
    @(negedge clk) a_if.start = 1'b0; a_if.out_ready = 1'b0;
    check_eq("taken_out_valid", a_if.out_valid, 0);
    check_eq("taken_busy", a_if.busy, 0);
    check_eq("taken_y_retained", a_y(1), 22);
    @(negedge clk);
    check_eq("no_new_job_busy", a_if.busy, 0);

    // same job with a 2-cycle stall between beats
    a_job(2, 1'b1, tot2, tail2);
    check_eq("stall_tail", tail2, 3);
    check_eq("stall_delay", tot2 - tot0, 2);
    a_check_y("a2");
    a_release();

    // reset during DRAIN
    a_job(0, 1'b0, tmp, ttmp);
    @(negedge clk) rst = 1'b1;
    #1;
    check_eq("drain_rst_y", a_if.y, 0);
    check_eq("drain_rst_out_valid", a_if.out_valid, 0);
    check_eq("drain_rst_busy", a_if.busy, 0);
    check_eq("drain_rst_in_ready", a_if.in_ready, 0);
    check_eq("drain_rst_ovf", a_if.ovf, 0);
    @(negedge clk) rst = 1'b0;
    a_job(0, 1'b1, tot0, tail0);
    check_eq("post_rst_tail", tail0, 3);
    a_check_y("a3");
    a_release();

    // 1x1x1 jobs
    b_job(8'd1, 8'd1, tmp);
    check_eq("b_tail", tmp, 1);
    check_eq("b_y_one", $signed(b_if.y), 1);
    b_if.out_ready = 1'b1;
    @(negedge clk) b_if.out_ready = 1'b0;
    b_job(8'h80, 8'h80, tmp);
    check_eq("b_y_neg", $signed(b_if.y), 16384);
    b_if.out_ready = 1'b1;
    @(negedge clk) b_if.out_ready = 1'b0;

    // overflow: 4 * 127 * 127
    @(negedge clk) c_if.start = 1'b1;
    @(negedge clk) c_if.start = 1'b0;
    c_if.in_valid = 1'b1; c_if.x_col = 8'd127; c_if.w_row = 8'd127;
    repeat (4) @(negedge clk);
    c_if.in_valid = 1'b0;
    tmp = 0;
    while (!c_if.out_valid && tmp < 50) begin
      @(negedge clk);
      tmp++;
    end
    check_eq("c_tail", tmp, 1);
`ifdef SA_SATURATE_EN
    check_eq("c_y_sat", $signed(c_if.y), 32767);
    check_eq("c_ovf", c_if.ovf, 1);
`else
    check_eq("c_y_wrap", $signed(c_if.y), -1020);
    check_eq("c_ovf", c_if.ovf, 0);
`endif
    c_if.out_ready = 1'b1;
    @(negedge clk) c_if.out_ready = 1'b0;
    c_if.start = 1'b1;
    @(negedge clk) c_if.start = 1'b0;
    check_eq("c_ovf_cleared", c_if.ovf, 0);
    check_eq("c_y_cleared", c_if.y, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
